// File: rtl/main_memory_arbiter_pkg.sv
// Shared types and defaults for the backing-memory arbiter and its line storage.
package main_memory_arbiter_pkg;

  localparam int DEF_CACHE_LINE_SIZE = 128;
  localparam int DEF_MEM_LATENCY     = 5;
  localparam int DEF_MEM_LINES       = 4096;
  localparam int NUM_PORTS           = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Latched per-transaction control: who was granted and whether it writes.
  typedef struct packed {
    port_e port;
    logic  wr;
  } txn_t;

  // Number of byte-offset bits inside one line.
  function automatic int line_ofs_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/main_memory_arbiter_mem_line_array.sv
// Line-organised storage: synchronous write, combinational read, not reset.
module mem_line_array #(
  parameter int    LINE_W    = 128,
  parameter int    LINES     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] waddr,
  input  logic [LINE_W-1:0]        wdata,
  input  logic [$clog2(LINES)-1:0] raddr,
  output logic [LINE_W-1:0]        rdata
);

  logic [LINE_W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/main_memory_arbiter.sv
// Two-port (I/D cache) arbiter serialising fixed-latency line transactions
// against a single line array; one-cycle ready pulse to the granted port.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int    CACHE_LINE_SIZE = DEF_CACHE_LINE_SIZE,
  parameter int    MEM_LATENCY     = DEF_MEM_LATENCY,
  parameter int    MEM_LINES       = DEF_MEM_LINES,
  parameter string INIT_FILE       = ""
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_read_en,
  input  logic [31:0]                in_i_addr,
  input  logic                       in_d_read_en,
  input  logic                       in_d_write_en,
  input  logic [31:0]                in_d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
  output logic                       out_i_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
  output logic                       out_d_ready,
  output logic                       out_busy
);

  localparam int OFS   = line_ofs_bits(CACHE_LINE_SIZE);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  state_e                                     state_q, state_d;
  logic [CNT_W-1:0]                           cnt_q, cnt_d;
  txn_t                                       txn_q;
  port_e                                      last_grant_q, grant_port;
  logic [IDX_W-1:0]                           line_q, grant_line;
  logic [CACHE_LINE_SIZE-1:0]                 wdata_q, mem_rdata;
  logic [NUM_PORTS-1:0][CACHE_LINE_SIZE-1:0]  rd_data_q;
  logic                                       i_req, d_req, load, mem_we, rd_cap;
  logic                                       unused_addr;

  // Only the line-index slice of each address matters; the rest wraps away.
  assign unused_addr = ^{in_i_addr, in_d_addr};

  assign i_req = in_i_read_en;
  assign d_req = in_d_read_en | in_d_write_en;

  // D has priority except right after its own grant, which bounds I's wait.
  assign grant_port = (d_req && !(i_req && last_grant_q == PORT_D)) ? PORT_D : PORT_I;
  assign grant_line = (grant_port == PORT_D) ? in_d_addr[OFS +: IDX_W]
                                             : in_i_addr[OFS +: IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    mem_we  = 1'b0;
    rd_cap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          load    = 1'b1;
          cnt_d   = LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mem_we  = txn_q.wr;
          rd_cap  = !txn_q.wr;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      txn_q        <= '{port: PORT_I, wr: 1'b0};
      last_grant_q <= PORT_I;
      line_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        txn_q.port   <= grant_port;
        txn_q.wr     <= (grant_port == PORT_D) && in_d_write_en;
        last_grant_q <= grant_port;
        line_q       <= grant_line;
        wdata_q      <= in_d_write_data;
      end
      if (rd_cap) rd_data_q[txn_q.port] <= mem_rdata;
    end
  end

  mem_line_array #(
    .LINE_W    (CACHE_LINE_SIZE),
    .LINES     (MEM_LINES),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (line_q),
    .wdata (wdata_q),
    .raddr (line_q),
    .rdata (mem_rdata)
  );

  assign out_i_read_data = rd_data_q[PORT_I];
  assign out_d_read_data = rd_data_q[PORT_D];
  assign out_i_ready     = (state_q == RESP) && (txn_q.port == PORT_I);
  assign out_d_ready     = (state_q == RESP) && (txn_q.port == PORT_D);
  assign out_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter with hand-computed expectations.
module tb_main_memory_arbiter;

  localparam int LW = 128;
  localparam int L  = 5;

  localparam logic [LW-1:0] D0  = 128'h0000_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [LW-1:0] D1  = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
  localparam logic [LW-1:0] D7  = 128'h7777_0000_7777_0000_7777_0000_7777_0007;
  localparam logic [LW-1:0] N7  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [LW-1:0] DB  = 128'hDEADBEEF_CAFEF00D_12345678_00000001;
  localparam logic [LW-1:0] AL  = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_i_read_en, in_d_read_en, in_d_write_en;
  logic [31:0]   in_i_addr, in_d_addr;
  logic [LW-1:0] in_d_write_data, out_i_read_data, out_d_read_data;
  logic          out_i_ready, out_d_ready, out_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_memory_arbiter #(
    .CACHE_LINE_SIZE (LW),
    .MEM_LATENCY     (L),
    .MEM_LINES       (4096)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_i_read_en    (in_i_read_en),
    .in_i_addr       (in_i_addr),
    .in_d_read_en    (in_d_read_en),
    .in_d_write_en   (in_d_write_en),
    .in_d_addr       (in_d_addr),
    .in_d_write_data (in_d_write_data),
    .out_i_read_data (out_i_read_data),
    .out_i_ready     (out_i_ready),
    .out_d_read_data (out_d_read_data),
    .out_d_ready     (out_d_ready),
    .out_busy        (out_busy)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the number of negedges until a ready pulse, or -1 on timeout.
  task automatic wait_rdy(input int limit, output int k, output logic is_d);
    k    = -1;
    is_d = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (out_i_ready || out_d_ready) begin
        k    = c;
        is_d = out_d_ready;
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_irdy"},  LW'(out_i_ready), '0);
    chk({tag, "_drdy"},  LW'(out_d_ready), '0);
    chk({tag, "_busy"},  LW'(out_busy), '0);
    chk({tag, "_idata"}, out_i_read_data, '0);
    chk({tag, "_ddata"}, out_d_read_data, '0);
  endtask

  // Single transaction starting from a negedge in IDLE; ends at the next IDLE negedge.
  task automatic xact(input string tag, input logic port_d, input logic wr, input logic also_rd,
                      input logic [31:0] addr, input logic [LW-1:0] wdata, input logic [LW-1:0] exp);
    int   k;
    logic isd;
    if (port_d) begin
      in_d_addr       = addr;
      in_d_write_data = wdata;
      in_d_write_en   = wr;
      in_d_read_en    = !wr || also_rd;
    end else begin
      in_i_addr    = addr;
      in_i_read_en = 1'b1;
    end
    wait_rdy(4 * L, k, isd);
    chk({tag, "_lat"},  LW'(k), LW'(L + 1));
    chk({tag, "_port"}, LW'(isd), LW'(port_d));
    chk({tag, "_both"}, LW'(out_i_ready & out_d_ready), '0);
    chk({tag, "_busy"}, LW'(out_busy), LW'(1));
    if (!wr) chk({tag, "_data"}, port_d ? out_d_read_data : out_i_read_data, exp);
    in_i_read_en  = 1'b0;
    in_d_read_en  = 1'b0;
    in_d_write_en = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, LW'(out_i_ready | out_d_ready), '0);
    chk({tag, "_idle"},  LW'(out_busy), '0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   k;
    logic isd;
    reset           = 1'b1;
    in_i_read_en    = 1'b0;
    in_d_read_en    = 1'b0;
    in_d_write_en   = 1'b0;
    in_i_addr       = '0;
    in_d_addr       = '0;
    in_d_write_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Preload lines 0, 1, 7; write completions must not touch read_data.
    xact("wr_l0", 1'b1, 1'b1, 1'b0, 32'h0000_0000, D0, '0);
    xact("wr_l1", 1'b1, 1'b1, 1'b0, 32'h0000_0010, D1, '0);
    xact("wr_l7", 1'b1, 1'b1, 1'b0, 32'h0000_0070, D7, '0);
    chk("wr_no_rdata", out_d_read_data, '0);

    // Array survives reset; I read of line 1 a few cycles after release.
    pulse_reset();
    check_reset_outputs("rst2");
    @(negedge clk);
    xact("i_rd_l1", 1'b0, 1'b0, 1'b0, 32'h0000_0010, '0, D1);
    chk("i_rd_d_quiet", out_d_read_data, '0);

    // Write then read the same line with different byte offsets.
    xact("d_wr_40", 1'b1, 1'b1, 1'b0, 32'h0000_0040, DB, '0);
    xact("d_rd_4c", 1'b1, 1'b0, 1'b0, 32'h0000_004C, '0, DB);

    // Simultaneous requests after reset: D first, I one period later.
    pulse_reset();
    in_i_addr    = 32'h0000_0010;
    in_i_read_en = 1'b1;
    in_d_addr    = 32'h0000_0040;
    in_d_read_en = 1'b1;
    wait_rdy(4 * L, k, isd);
    chk("sim_d_lat",  LW'(k), LW'(L + 1));
    chk("sim_d_port", LW'(isd), LW'(1));
    chk("sim_d_data", out_d_read_data, DB);
    chk("sim_i_wait", LW'(out_i_ready), '0);
    in_d_read_en = 1'b0;
    wait_rdy(4 * L, k, isd);
    chk("sim_i_lat",  LW'(k), LW'(L + 2));
    chk("sim_i_port", LW'(isd), LW'(0));
    chk("sim_i_data", out_i_read_data, D1);

    // Both held high: grants alternate D, I, D, I at the full period.
    in_d_read_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_rdy(4 * L, k, isd);
      chk($sformatf("alt%0d_lat", j),  LW'(k), LW'(L + 2));
      chk($sformatf("alt%0d_port", j), LW'(isd), LW'((j % 2) == 0));
      chk($sformatf("alt%0d_data", j), isd ? out_d_read_data : out_i_read_data, isd ? DB : D1);
    end
    in_i_read_en = 1'b0;
    in_d_read_en = 1'b0;
    @(negedge clk);

    // Read+write together is a write; high address bits alias to line 0.
    xact("rw_both_l0", 1'b1, 1'b1, 1'b1, 32'h0000_0000, AL, '0);
    chk("rw_no_rdata", out_d_read_data, DB);
    xact("alias_rd",   1'b0, 1'b0, 1'b0, 32'h0001_0000, '0, AL);

    // Reset during BUSY of a write aborts it completely.
    in_d_addr       = 32'h0000_0070;
    in_d_write_data = N7;
    in_d_write_en   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", LW'(out_busy), LW'(1));
    in_d_write_en = 1'b0;
    reset         = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", c), LW'({out_i_ready, out_d_ready, out_busy}), '0);
    end
    xact("abort_l7", 1'b1, 1'b0, 1'b0, 32'h0000_0070, '0, D7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
